// File: rtl/tx_stream_arbiter.sv
// Round-robin, packet-atomic arbiter that merges several byte streams
// onto a single registered UART TX valid/ready output stage.
module tx_stream_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic [IDX_WIDTH-1:0]          grant_id
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]            state;
  logic [IDX_WIDTH-1:0]  rr_ptr;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [IDX_WIDTH-1:0]  cand;
  logic                  sel_any;
  logic                  out_free;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  src_xfer;
  int                    j;

  assign out_free = ~tx_valid | tx_ready;
  assign busy     = (state == STREAM);

  // First requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    sel_idx = rr_ptr;
    sel_any = 1'b0;
    cand    = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_WIDTH'(j);
      if (!sel_any && req_valid[cand]) begin
        sel_idx = cand;
        sel_any = 1'b1;
      end
    end
  end

  // Mux the granted source and decide whether its beat moves this cycle
  always_comb begin
    g_valid  = req_valid[grant_id];
    g_last   = req_last[grant_id];
    g_data   = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    src_xfer = (state == STREAM) & out_free & g_valid;
  end

  // Only the granted source sees ready, and only when the stage can take a byte
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == STREAM) &&
                     (grant_id == IDX_WIDTH'(i)) &&
                     out_free;
    end
  end

  // Grant FSM: one arbitration cycle, then hold until the last beat moves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            grant_id <= sel_idx;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (src_xfer && g_last) begin
            state  <= IDLE;
            rr_ptr <= (grant_id == IDX_WIDTH'(NUM_REQ-1)) ?
                      '0 : grant_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output byte register: load on source beat, empty on accepted output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (src_xfer) begin
      tx_valid <= 1'b1;
      tx_data  <= g_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: doc/tx_stream_arbiter.md
Name: tx_stream_arbiter

Overview:
- Shares the single UART transmit byte stream between NUM_REQ packet sources, e.g. the board printer, the result printer and the prompt/message printer under game_manager.
- Grants are round-robin and packet-atomic. A grant is held from the first byte until the byte flagged last is accepted, so printouts never interleave.
- The output is one registered byte stage that drives the UART TX valid/ready interface.

Parameters:
NUM_REQ, 3, number of requesting byte-stream sources (2..8)
DATA_WIDTH, 8, byte width of each stream
IDX_WIDTH, $clog2(NUM_REQ), width of grant index (derived; not overridden)

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  asynchronous, active-low reset (asserted when 0); clears all state immediately
req_valid  in  NUM_REQ  per-source byte valid
req_data  in  NUM_REQ*DATA_WIDTH  per-source byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  marks final byte of the source's packet
req_ready  out  NUM_REQ  per-source accept; at most one bit high
tx_valid  out  1  output byte valid
tx_data  out  DATA_WIDTH  output byte
tx_ready  in  1  UART TX accepts byte
busy  out  1  high while a packet is granted (state STREAM)
grant_id  out  IDX_WIDTH  index of current/last granted source

Behaviour:
- Reset (reset=0, async) sets: state=IDLE, rr_ptr=0, grant_id=0, busy=0, tx_valid=0, tx_data=0, req_ready=0.
- Transfer rules:
  - A source beat transfers on a clock edge where req_valid[i] & req_ready[i].
  - An output beat transfers on an edge where tx_valid & tx_ready.
- Output register:
  - out_free = ~tx_valid | tx_ready.
  - On a source transfer, tx_data<=byte and tx_valid<=1.
  - Else on an output transfer, tx_valid<=0.
  - tx_data holds while tx_valid & ~tx_ready.
  - Full throughput: 1 byte/cycle when tx_ready is held high.
- req_ready[i] = (state==STREAM) & (grant_id==i) & out_free. It is combinational from registered state and tx_ready. It does not depend on req_valid.
- State IDLE:
  - busy=0, req_ready=0.
  - If any req_valid, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - grant_id<=selected, state<=STREAM.
  - Arbitration costs exactly 1 cycle.
  - With no valid, remain in IDLE; grant_id keeps its last value.
- State STREAM:
  - busy=1.
  - Each granted beat transfer is forwarded to the output register.
  - When the transferred beat has req_last=1: state<=IDLE and rr_ptr<=(grant_id==NUM_REQ-1)?0:grant_id+1.
  - Granted source dropping req_valid mid-packet: grant is held, no bytes are emitted, and the arbiter waits indefinitely. There is no timeout.
  - req_valid from non-granted sources is ignored; those sources see req_ready=0.
- Latency: a source raises req_valid at cycle t in IDLE → grant registered at edge t/t+1 → req_ready high during t+1 (if out_free) → first byte on tx_valid/tx_data in cycle t+2.
- Packet gap: after a last beat, the next grant takes 1 IDLE cycle. The output register may still hold the last byte during that cycle; this is permitted.
- Single-byte packet (req_last on first beat): STREAM lasts one transfer cycle, then IDLE.
- Simultaneous requests: only the round-robin winner is granted. Losers keep valid asserted and are served in rotation order; no source waits more than NUM_REQ-1 packets.
- Backpressure: tx_ready=0 with tx_valid=1 holds tx_data and forces req_ready=0. Nothing is dropped or duplicated.
- Reset mid-packet clears everything, including any byte held in the output register (tx_valid=0). The partial packet is discarded, and sources must restart their packets.
- Output signals are registered except req_ready (see above).

Test Plan:
- Reset: reset=0 with all sources valid → tx_valid=0, busy=0, req_ready=0, grant_id=0. Release → grant to source 0 one cycle later.
- Single source: source 1 sends 0x41,0x42,0x43(last) with tx_ready=1 → tx_data 0x41,0x42,0x43 on consecutive cycles starting 2 cycles after valid. Then busy=0 and rr_ptr=2.
- Contention: sources 0,1,2 each send a 2-byte packet (0x0n,0x1n) simultaneously from reset → output order 00,10,01,11,02,12. No interleaving within a packet. 1 idle arbitration cycle between packets.
- Rotation: after source 2 finishes, sources 0 and 2 both request → source 0 is granted first (wrap from rr_ptr=0).
- Backpressure: tx_ready toggles 1,0,0,1 during a 4-byte packet 0xA0..0xA3 → every byte appears exactly once, in order. tx_data is stable while tx_ready=0, and req_ready=0 on stalled cycles.
- Mid-packet stall and reset: granted source deasserts valid after 1 byte → busy stays 1 and source 2's valid is not served. Asserting reset=0 then clears busy/tx_valid, and after release source 0 (rr_ptr=0) is granted.
